// File: rtl/code_entry.sv
// ---------------------------------------------------------------------------
// code_entry
//   Digit-entry front end for the unlocker. Collects single-digit key events
//   into four username slots followed by four password slots and publishes
//   the running digit count. The entry is cleared by resetCount, by
//   backspacing to empty, or (optionally) after an inactivity timeout.
//
// Optional feature macro: CODE_ENTRY_TIMEOUT_EN
//   defined     -> idle counter built, partial entries time out, timedOut pulses
//   not defined -> no idle counter, partial entries persist, timedOut = 0
//
// Ports
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   keyValid       in   one-cycle pulse, keyValue holds a new digit
//   keyValue       in   digit value [DIGIT_W-1:0]
//   keyBack        in   one-cycle pulse, delete last digit
//   resetCount     in   level, clear the whole entry
//   inputCount     out  digits held, 0..8
//   userNameInput0..3 / passwordInput0..3  out  digit slots
//   entryDone      out  pulse after the 8th digit is stored
//   entryError     out  pulse after a rejected key/back event
//   timedOut       out  pulse after a timeout clear
// ---------------------------------------------------------------------------
module code_entry #(
    parameter int DIGIT_W        = 5,
    parameter int MAX_DIGIT      = 9,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               keyValid,
    input  logic [DIGIT_W-1:0] keyValue,
    input  logic               keyBack,
    input  logic               resetCount,
    output logic [3:0]         inputCount,
    output logic [DIGIT_W-1:0] userNameInput0,
    output logic [DIGIT_W-1:0] userNameInput1,
    output logic [DIGIT_W-1:0] userNameInput2,
    output logic [DIGIT_W-1:0] userNameInput3,
    output logic [DIGIT_W-1:0] passwordInput0,
    output logic [DIGIT_W-1:0] passwordInput1,
    output logic [DIGIT_W-1:0] passwordInput2,
    output logic [DIGIT_W-1:0] passwordInput3,
    output logic               entryDone,
    output logic               entryError,
    output logic               timedOut
);

    // Slots 0..3 are the username, 4..7 the password; the slot written by
    // the next key is simply the current count.
    logic [DIGIT_W-1:0] slots_q [8];
    logic [DIGIT_W-1:0] slots_d [8];
    logic [3:0]         count_q, count_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               activity;      // accepted key or back event this cycle
    logic               timeout_hit;   // timeout clear this cycle
    logic [2:0]         back_idx;
    logic               partial;       // count in 1..7

    assign back_idx = 3'(count_q - 4'd1);
    assign partial  = (count_q != 4'd0) && (count_q != 4'd8);

`ifdef CODE_ENTRY_TIMEOUT_EN
    localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              tmo_q;

    assign timeout_hit = !resetCount && !activity && partial && (idle_q == IDLE_LAST);

    // Idle counter only runs on a partial entry and saturates rather than wraps.
    always_comb begin
        idle_d = idle_q;
        if (resetCount || activity || timeout_hit ||
            count_d == 4'd0 || count_d == 4'd8) begin
            idle_d = '0;
        end else if (idle_q != {IDLE_W{1'b1}}) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            idle_q <= idle_d;
            tmo_q  <= timeout_hit;
        end
    end

    assign timedOut = tmo_q;
`else
    assign timeout_hit = 1'b0;
    assign timedOut    = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < 8; i++) slots_d[i] = slots_q[i];
        count_d  = count_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        activity = 1'b0;
        if (resetCount) begin
            // Coincident key/back events are silently discarded.
            for (int i = 0; i < 8; i++) slots_d[i] = '0;
            count_d = 4'd0;
        end else if (keyBack) begin
            if (count_q != 4'd0) begin
                count_d           = count_q - 4'd1;
                slots_d[back_idx] = '0;
                activity          = 1'b1;
            end else begin
                err_d = 1'b1;
            end
            if (keyValid) err_d = 1'b1;
        end else if (keyValid) begin
            if (keyValue > DIGIT_W'(MAX_DIGIT) || count_q == 4'd8) begin
                err_d = 1'b1;
            end else begin
                slots_d[count_q[2:0]] = keyValue;
                count_d               = count_q + 4'd1;
                activity              = 1'b1;
                done_d                = (count_q == 4'd7);
            end
        end
        if (timeout_hit) begin
            for (int i = 0; i < 8; i++) slots_d[i] = '0;
            count_d = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) slots_q[i] <= '0;
            count_q <= 4'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) slots_q[i] <= slots_d[i];
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign inputCount     = count_q;
    assign entryDone      = done_q;
    assign entryError     = err_q;
    assign userNameInput0 = slots_q[0];
    assign userNameInput1 = slots_q[1];
    assign userNameInput2 = slots_q[2];
    assign userNameInput3 = slots_q[3];
    assign passwordInput0 = slots_q[4];
    assign passwordInput1 = slots_q[5];
    assign passwordInput2 = slots_q[6];
    assign passwordInput3 = slots_q[7];

endmodule

// File: tb/tb_code_entry.sv
// ---------------------------------------------------------------------------
// tb_code_entry
//   Table-driven bench for code_entry plus hand-written sequences for the
//   asynchronous reset and the (build-dependent) timeout behaviour.
//   Expected slot contents are written as 8 hex nibbles, slot 0 (username
//   digit 1) in the most significant nibble.
// ---------------------------------------------------------------------------
module tb_code_entry;

    localparam int DIGIT_W = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               keyValid = 1'b0;
    logic [DIGIT_W-1:0] keyValue = '0;
    logic               keyBack = 1'b0;
    logic               resetCount = 1'b0;
    logic [3:0]         inputCount;
    logic [DIGIT_W-1:0] u0, u1, u2, u3, p0, p1, p2, p3;
    logic               entryDone, entryError, timedOut;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    code_entry #(.DIGIT_W(DIGIT_W), .MAX_DIGIT(9), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .keyValid(keyValid), .keyValue(keyValue), .keyBack(keyBack),
        .resetCount(resetCount), .inputCount(inputCount),
        .userNameInput0(u0), .userNameInput1(u1),
        .userNameInput2(u2), .userNameInput3(u3),
        .passwordInput0(p0), .passwordInput1(p1),
        .passwordInput2(p2), .passwordInput3(p3),
        .entryDone(entryDone), .entryError(entryError), .timedOut(timedOut)
    );

    typedef struct {
        logic        rstc;
        logic        back;
        logic        valid;
        logic [4:0]  val;
        logic [3:0]  cnt;
        logic [31:0] slots;
        logic        done;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rstc, input logic back, input logic valid,
                                input logic [4:0] val, input logic [3:0] cnt,
                                input logic [31:0] slots, input logic done, input logic err);
        vec_t v;
        v.rstc = rstc; v.back = back; v.valid = valid; v.val = val;
        v.cnt = cnt; v.slots = slots; v.done = done; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s #%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    function automatic logic [31:0] pack_slots();
        logic [DIGIT_W-1:0] s [8];
        logic [31:0] r;
        s[0] = u0; s[1] = u1; s[2] = u2; s[3] = u3;
        s[4] = p0; s[5] = p1; s[6] = p2; s[7] = p3;
        r = '0;
        // Any slot value above 15 cannot be represented, flag it as F.
        for (int i = 0; i < 8; i++)
            r[31-4*i -: 4] = (s[i] > 5'd15) ? 4'hF : s[i][3:0];
        return r;
    endfunction

    task automatic step(input logic rstc, input logic back, input logic valid,
                        input logic [4:0] val);
        resetCount = rstc; keyBack = back; keyValid = valid; keyValue = val;
        @(posedge clk);
        #1;
        resetCount = 1'b0; keyBack = 1'b0; keyValid = 1'b0; keyValue = '0;
    endtask

    task automatic check_state(input string name, input int idx, input logic [3:0] cnt,
                               input logic [31:0] slots, input logic done, input logic err);
        chk({name, "_count"}, idx, 32'(inputCount), 32'(cnt));
        chk({name, "_slots"}, idx, pack_slots(), slots);
        chk({name, "_done"}, idx, 32'(entryDone), 32'(done));
        chk({name, "_err"}, idx, 32'(entryError), 32'(err));
        $display("txn %s #%0d count=%0d slots=%08h done=%0b err=%0b tmo=%0b",
                 name, idx, inputCount, pack_slots(), entryDone, entryError, timedOut);
    endtask

    initial begin
        // Full entry 0,0,1,1,0,0,1,1 back to back, then FULL behaviour.
        tbl.push_back(mk(0,0,1,5'd0, 4'd1, 32'h0000_0000, 0,0));
        tbl.push_back(mk(0,0,1,5'd0, 4'd2, 32'h0000_0000, 0,0));
        tbl.push_back(mk(0,0,1,5'd1, 4'd3, 32'h0010_0000, 0,0));
        tbl.push_back(mk(0,0,1,5'd1, 4'd4, 32'h0011_0000, 0,0));
        tbl.push_back(mk(0,0,1,5'd0, 4'd5, 32'h0011_0000, 0,0));
        tbl.push_back(mk(0,0,1,5'd0, 4'd6, 32'h0011_0000, 0,0));
        tbl.push_back(mk(0,0,1,5'd1, 4'd7, 32'h0011_0010, 0,0));
        tbl.push_back(mk(0,0,1,5'd1, 4'd8, 32'h0011_0011, 1,0));
        tbl.push_back(mk(0,0,1,5'd3, 4'd8, 32'h0011_0011, 0,1));
        tbl.push_back(mk(0,0,0,5'd0, 4'd8, 32'h0011_0011, 0,0));
        tbl.push_back(mk(1,0,0,5'd0, 4'd0, 32'h0000_0000, 0,0));
        tbl.push_back(mk(0,0,0,5'd0, 4'd0, 32'h0000_0000, 0,0));
        // Keys 1,2,3 then backspace to empty and one more.
        tbl.push_back(mk(0,0,1,5'd1, 4'd1, 32'h1000_0000, 0,0));
        tbl.push_back(mk(0,0,1,5'd2, 4'd2, 32'h1200_0000, 0,0));
        tbl.push_back(mk(0,0,1,5'd3, 4'd3, 32'h1230_0000, 0,0));
        tbl.push_back(mk(0,1,0,5'd0, 4'd2, 32'h1200_0000, 0,0));
        tbl.push_back(mk(0,1,0,5'd0, 4'd1, 32'h1000_0000, 0,0));
        tbl.push_back(mk(0,1,0,5'd0, 4'd0, 32'h0000_0000, 0,0));
        tbl.push_back(mk(0,1,0,5'd0, 4'd0, 32'h0000_0000, 0,1));
        // Out-of-range key, then key coincident with back.
        tbl.push_back(mk(0,0,1,5'd4, 4'd1, 32'h4000_0000, 0,0));
        tbl.push_back(mk(0,0,1,5'd5, 4'd2, 32'h4500_0000, 0,0));
        tbl.push_back(mk(0,0,1,5'd6, 4'd3, 32'h4560_0000, 0,0));
        tbl.push_back(mk(0,0,1,5'd12,4'd3, 32'h4560_0000, 0,1));
        tbl.push_back(mk(0,1,1,5'd7, 4'd2, 32'h4500_0000, 0,1));
        // resetCount beats coincident key and back without an error.
        tbl.push_back(mk(1,0,1,5'd5, 4'd0, 32'h0000_0000, 0,0));
        tbl.push_back(mk(0,0,1,5'd9, 4'd1, 32'h9000_0000, 0,0));
        tbl.push_back(mk(0,0,1,5'd10,4'd1, 32'h9000_0000, 0,1));
        tbl.push_back(mk(1,1,0,5'd0, 4'd0, 32'h0000_0000, 0,0));

        // Reset state.
        #12;
        check_state("reset", 0, 4'd0, 32'h0, 1'b0, 1'b0);
        chk("reset_tmo", 0, 32'(timedOut), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rstc, tbl[i].back, tbl[i].valid, tbl[i].val);
            check_state("vec", i, tbl[i].cnt, tbl[i].slots, tbl[i].done, tbl[i].err);
        end

        // Asynchronous reset mid-entry at count 5.
        for (int i = 0; i < 5; i++) step(0, 0, 1, 5'(i + 1));
        check_state("pre_arst", 0, 4'd5, 32'h1234_5000, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_state("arst", 0, 4'd0, 32'h0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(0, 0, 1, 5'd7);
        check_state("after_arst", 0, 4'd1, 32'h7000_0000, 1'b0, 1'b0);
        step(1, 0, 0, 5'd0);

`ifdef CODE_ENTRY_TIMEOUT_EN
        step(0, 0, 1, 5'd3);
        step(0, 0, 1, 5'd4);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 5'd0);
        check_state("tmo_pre", 0, 4'd2, 32'h3400_0000, 1'b0, 1'b0);
        chk("tmo_pre_pulse", 0, 32'(timedOut), 32'd0);
        step(0, 0, 0, 5'd0);
        check_state("tmo_hit", 0, 4'd0, 32'h0, 1'b0, 1'b0);
        chk("tmo_pulse", 0, 32'(timedOut), 32'd1);
        step(0, 0, 0, 5'd0);
        chk("tmo_pulse_end", 0, 32'(timedOut), 32'd0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 5'd8);
        begin
            int tmo_seen = 0;
            for (int i = 0; i < 40; i++) begin
                step(0, 0, 0, 5'd0);
                if (timedOut) tmo_seen++;
            end
            chk("full_no_tmo", 0, 32'(tmo_seen), 32'd0);
        end
        check_state("full_hold", 0, 4'd8, 32'h8888_8888, 1'b0, 1'b0);
`else
        step(0, 0, 1, 5'd3);
        step(0, 0, 1, 5'd4);
        begin
            int tmo_seen = 0;
            for (int i = 0; i < 40; i++) begin
                step(0, 0, 0, 5'd0);
                if (timedOut) tmo_seen++;
            end
            chk("no_tmo_pulse", 0, 32'(tmo_seen), 32'd0);
        end
        check_state("persist", 0, 4'd2, 32'h3400_0000, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
